// File: rtl/traffic_phase_timer_if.sv
// Signal bundle between the phase timer and its consumers (display stage, lamp drivers, bench).
// The timer sits on the slave side; whoever drives ped_req is the master.
interface traffic_phase_timer_if;
   logic       ped_req;
   logic [3:0] counter;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic       walk;
   logic [2:0] phase;

   modport master (
      output ped_req,
      input  counter, ns_light, ew_light, walk, phase
   );

   modport slave (
      input  ped_req,
      output counter, ns_light, ew_light, walk, phase
   );
endinterface

// File: rtl/traffic_phase_timer.sv
// Six-phase intersection sequencer with 1 s prescaler, per-phase countdown and pedestrian
// request handling (NS-green shortening, walk grant during EW green).
module traffic_phase_timer #(
   parameter int unsigned TICKS_PER_SEC = 50_000_000,
   parameter int unsigned GREEN_DUR     = 10,
   parameter int unsigned YELLOW_DUR    = 3,
   parameter int unsigned ALLRED_DUR    = 2,
   parameter int unsigned PED_MIN       = 3
) (
   input logic                   CLOCK_50,
   input logic                   resetn,
   traffic_phase_timer_if.slave  bus
);

   localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

   typedef enum logic [2:0] {
      StNsGreen  = 3'd0,
      StNsYellow = 3'd1,
      StAllRedA  = 3'd2,
      StEwGreen  = 3'd3,
      StEwYellow = 3'd4,
      StAllRedB  = 3'd5
   } state_e;

   logic [PW-1:0] presc_q, presc_d;
   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          pend_q, pend_d;
   logic          walk_q, walk_d;
   logic          step;
   state_e        nxt;

   function automatic logic [3:0] dur_of(state_e s);
      logic [3:0] d;
      unique case (s)
         StNsGreen, StEwGreen:   d = 4'(GREEN_DUR);
         StNsYellow, StEwYellow: d = 4'(YELLOW_DUR);
         default:                d = 4'(ALLRED_DUR);
      endcase
      return d;
   endfunction

   assign step = (presc_q == PW'(TICKS_PER_SEC - 1));
   assign nxt  = (state_q == StAllRedB) ? StNsGreen : state_e'(state_q + 3'd1);

   always_comb begin
      presc_d = step ? '0 : presc_q + PW'(1);
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q | bus.ped_req;
      walk_d  = walk_q;
      if (step) begin
         if (cnt_q == 4'd1) begin
            state_d = nxt;
            cnt_d   = dur_of(nxt);
            if (state_q == StEwGreen) begin
               walk_d = 1'b0;
            end
            // Entering EW green consumes the request; a same-cycle request still counts.
            if (nxt == StEwGreen) begin
               walk_d = pend_q | bus.ped_req;
               pend_d = 1'b0;
            end
         end else if (state_q == StNsGreen && pend_q && cnt_q > 4'(PED_MIN)) begin
            cnt_d = 4'(PED_MIN);
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         presc_q <= '0;
         state_q <= StNsGreen;
         cnt_q   <= 4'(GREEN_DUR);
         pend_q  <= 1'b0;
         walk_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         walk_q  <= walk_d;
      end
   end

   // Lamps decode only from the registered state, so they cannot glitch.
   always_comb begin
      bus.ns_light = 3'b100;
      bus.ew_light = 3'b100;
      unique case (state_q)
         StNsGreen:  bus.ns_light = 3'b001;
         StNsYellow: bus.ns_light = 3'b010;
         StEwGreen:  bus.ew_light = 3'b001;
         StEwYellow: bus.ew_light = 3'b010;
         default: begin
            bus.ns_light = 3'b100;
            bus.ew_light = 3'b100;
         end
      endcase
   end

   assign bus.counter = cnt_q;
   assign bus.walk    = walk_q;
   assign bus.phase   = state_q;

endmodule

// File: doc/traffic_phase_timer.md
Name: traffic_phase_timer

Overview:
- Upstream stage of the HEX6/HEX7 countdown display and the light drivers.
- Sequences the intersection through six fixed phases.
- Generates a 1 s tick from the board clock and produces the 4-bit per-phase countdown value (range 1..10) consumed by the seven-segment display stage.
- Latches a pedestrian request that shortens north-south green and grants a walk signal during east-west green.

Parameters:
- TICKS_PER_SEC, 50_000_000: clock cycles per countdown step. Legal range ≥ 2; set to 4 in simulation.
- GREEN_DUR, 10: green phase length in ticks, 1..10.
- YELLOW_DUR, 3: yellow phase length in ticks, 1..10.
- ALLRED_DUR, 2: all-red phase length in ticks, 1..10.
- PED_MIN, 3: remaining NS-green ticks after a pedestrian request, 1..GREEN_DUR.

Ports:
- CLOCK_50  in  1  system clock
- resetn  in  1  synchronous active-low reset
- ped_req  in  1  pedestrian request, active-high level, already synchronised
- counter  out  4  countdown value for the display stage, 1..10
- ns_light  out  3  {red, yellow, green} north-south lamps, one-hot
- ew_light  out  3  {red, yellow, green} east-west lamps, one-hot
- walk  out  1  pedestrian walk lamp
- phase  out  3  current state encoding, for debug and the bench

Behaviour:
- Reset:
  - Sampled on CLOCK_50 rising edge while resetn=0.
  - Reset values: prescaler=0, state=NS_GREEN, counter=GREEN_DUR, ped_pending=0, walk=0, ns_light=3'b001, ew_light=3'b100.
  - Reset mid-phase discards all progress; the next cycle behaves as first cycle after reset.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1; wraps to 0.
  - Step event = the edge at which the prescaler equals TICKS_PER_SEC-1.
  - First step occurs on the TICKS_PER_SEC-th rising edge after resetn goes high.
  - All counter and state updates occur only on step edges, except ped_pending.
- States and encodings, in order, cyclic:
  - NS_GREEN(0): ns=001, ew=100
  - NS_YELLOW(1): ns=010, ew=100
  - ALLRED_A(2): ns=100, ew=100
  - EW_GREEN(3): ns=100, ew=001
  - EW_YELLOW(4): ns=100, ew=010
  - ALLRED_B(5): ns=100, ew=100
  - ALLRED_B is followed by NS_GREEN.
- Step rule:
  - counter==1: advance to the next state and load that state's duration.
  - Otherwise: counter←counter-1.
  - counter never reaches 0; every phase lasts exactly DUR steps.
- Pedestrian shortening:
  - Applies on a step edge in NS_GREEN with ped_pending=1 and counter>PED_MIN: counter←PED_MIN instead of decrementing.
  - No shortening if counter≤PED_MIN.
  - Never lengthens a phase.
- ped_pending:
  - Set on any cycle with ped_req=1.
  - Cleared on the step edge that enters EW_GREEN.
  - Set has priority in every other cycle.
- walk:
  - On the step edge entering EW_GREEN: walk←(ped_pending | ped_req).
  - walk←0 on the step edge leaving EW_GREEN.
  - A request arriving during EW_GREEN stays pending for the next cycle; it does not raise walk mid-phase.
- Output timing: light and walk outputs are registered, or decoded purely from the registered state; outputs are glitch-free.
- Safety invariant: ns_light and ew_light green/yellow are never both non-red in the same cycle.

Test Plan:
1. Reset, TICKS_PER_SEC=4, defaults, no ped_req:
   - counter sequence per 4 cycles: 10,9,…,1 (NS_GREEN), then 3,2,1 (NS_YELLOW), 2,1, 10..1 (EW_GREEN), 3..1, 2,1, back to 10 in NS_GREEN.
   - Full cycle = 30 steps = 120 cycles.
2. Pedestrian shortening:
   - Pulse ped_req one cycle while NS_GREEN counter=8.
   - Next step: counter=3, then 2,1, then NS_YELLOW.
   - walk=1 throughout the following EW_GREEN; 0 after it; ped_pending=0.
3. Late request:
   - ped_req while NS_GREEN counter=2 → counter 1 then NS_YELLOW, no shortening.
   - walk=1 in next EW_GREEN.
4. ped_req asserted in the cycle before the EW_GREEN entry step:
   - walk=1 for that EW_GREEN; pending cleared.
   - ped_req during EW_GREEN (counter=5) → walk stays 1 until phase end; request shortens the next NS_GREEN to PED_MIN at its first step.
5. Reset mid-EW_YELLOW with counter=2:
   - Hold resetn=0 one cycle → state NS_GREEN, counter=10, walk=0, pending=0.
   - Next step is 4 cycles after release.
6. Invariant and range checks over 3 full cycles with random ped_req:
   - Assert no simultaneous non-red NS/EW lamps.
   - counter always in 1..10.
   - lamp vectors always one-hot.
